// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache miss fills onto one shared word-wide memory port.
// D-side wins simultaneous requests; one block is issued and received per grant.
module mem_fill_arbiter #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icache_miss,
    input  logic [15:0]                    icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [15:0]                    dcache_miss_addr,
    output logic                           mem_en,
    output logic [15:0]                    mem_addr,
    input  logic                           mem_data_valid,
    output logic                           fill_wen_i,
    output logic                           fill_wen_d,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           fill_done_i,
    output logic                           fill_done_d,
    output logic                           istall,
    output logic                           dstall
);

    localparam int WW = $clog2(BLOCK_WORDS);
    localparam logic [15:0] OFS_MASK  = 16'(2 * BLOCK_WORDS - 1);
    localparam logic [WW:0] ISSUE_END = (WW + 1)'(BLOCK_WORDS);
    localparam logic [WW-1:0] RX_LAST = WW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, DONE_I, DONE_D} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW:0]   issue_cnt;
    logic [WW-1:0] rx_cnt;
    logic [15:0]   base_addr;
    logic          filling;
    logic          rx_fire;

    assign filling = (state == FILL_I) || (state == FILL_D);
    assign rx_fire = filling && mem_data_valid;

    // Counters restart in every IDLE cycle so a grant always begins at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rx_cnt    <= '0;
            base_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                issue_cnt <= '0;
                rx_cnt    <= '0;
                if (dcache_miss)
                    base_addr <= dcache_miss_addr & ~OFS_MASK;
                else if (icache_miss)
                    base_addr <= icache_miss_addr & ~OFS_MASK;
            end else if (filling) begin
                if (issue_cnt != ISSUE_END)
                    issue_cnt <= issue_cnt + 1'b1;
                if (rx_fire && (rx_cnt != RX_LAST))
                    rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_wen_i  = 1'b0;
        fill_wen_d  = 1'b0;
        fill_word   = '0;
        fill_done_i = 1'b0;
        fill_done_d = 1'b0;

        if (filling && (issue_cnt != ISSUE_END)) begin
            mem_en   = 1'b1;
            mem_addr = base_addr + (16'(issue_cnt) << 1);
        end
        if (rx_fire)
            fill_word = rx_cnt;

        case (state)
            IDLE: begin
                if (dcache_miss)
                    state_nxt = FILL_D;
                else if (icache_miss)
                    state_nxt = FILL_I;
            end
            FILL_I: begin
                fill_wen_i = mem_data_valid;
                if (rx_fire && (rx_cnt == RX_LAST))
                    state_nxt = DONE_I;
            end
            FILL_D: begin
                fill_wen_d = mem_data_valid;
                if (rx_fire && (rx_cnt == RX_LAST))
                    state_nxt = DONE_D;
            end
            DONE_I: begin
                fill_done_i = 1'b1;
                state_nxt   = IDLE;
            end
            DONE_D: begin
                fill_done_d = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // In DONE the served requester is released, so only the other side's miss keeps the stall.
    always_comb begin
        istall = 1'b0;
        case (state)
            IDLE:           istall = icache_miss | dcache_miss;
            FILL_I, FILL_D: istall = 1'b1;
            DONE_I:         istall = dcache_miss;
            DONE_D:         istall = icache_miss;
            default:        istall = 1'b1;
        endcase
        dstall = istall;
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency (L=4) memory model.
// Fill timing: cycle 0 is the first FILL cycle, data at cycles 4..11, DONE at cycle 12.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic        fill_wen_i;
    logic        fill_wen_d;
    logic [2:0]  fill_word;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        istall;
    logic        dstall;

    logic        stray_valid;
    logic [3:0]  vpipe = '0;
    int          n_checks = 0;
    int          n_bad = 0;

    mem_fill_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .mem_en           (mem_en),
        .mem_addr         (mem_addr),
        .mem_data_valid   (mem_data_valid),
        .fill_wen_i       (fill_wen_i),
        .fill_wen_d       (fill_wen_d),
        .fill_word        (fill_word),
        .fill_done_i      (fill_done_i),
        .fill_done_d      (fill_done_d),
        .istall           (istall),
        .dstall           (dstall)
    );

    always #5 clk = ~clk;

    // Memory answers each request exactly four cycles after mem_en.
    always @(posedge clk) vpipe <= {vpipe[2:0], mem_en};
    assign mem_data_valid = vpipe[3] | stray_valid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic imiss, input logic [15:0] iaddr,
                                 input logic dmiss, input logic [15:0] daddr);
        icache_miss      = imiss;
        icache_miss_addr = iaddr;
        dcache_miss      = dmiss;
        dcache_miss_addr = daddr;
    endtask

    task automatic checkQuiet(input string tag, input logic exp_stall);
        checkOutput({tag, ".mem_en"}, mem_en, 0);
        checkOutput({tag, ".wen_i"}, fill_wen_i, 0);
        checkOutput({tag, ".wen_d"}, fill_wen_d, 0);
        checkOutput({tag, ".done_i"}, fill_done_i, 0);
        checkOutput({tag, ".done_d"}, fill_done_d, 0);
        checkOutput({tag, ".istall"}, istall, exp_stall);
        checkOutput({tag, ".dstall"}, dstall, exp_stall);
    endtask

    // Called on the negedge before the grant edge; returns on the DONE-cycle negedge.
    task automatic watchFill(input string tag, input bit is_d, input logic [15:0] base,
                             input int raise_other_at, input logic [15:0] other_addr,
                             input int drop_at, input bit extra_valid);
        logic own_wen, oth_wen, own_done, oth_done, exp_stall;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            own_wen  = is_d ? fill_wen_d : fill_wen_i;
            oth_wen  = is_d ? fill_wen_i : fill_wen_d;
            own_done = is_d ? fill_done_d : fill_done_i;
            oth_done = is_d ? fill_done_i : fill_done_d;
            checkOutput($sformatf("%s.mem_en[%0d]", tag, c), mem_en, (c < 8) ? 1 : 0);
            if (c < 8)
                checkOutput($sformatf("%s.mem_addr[%0d]", tag, c), mem_addr, base + 16'(2 * c));
            checkOutput($sformatf("%s.wen[%0d]", tag, c), own_wen, (c >= 4 && c < 12) ? 1 : 0);
            checkOutput($sformatf("%s.wen_other[%0d]", tag, c), oth_wen, 0);
            if (c >= 4 && c < 12)
                checkOutput($sformatf("%s.fill_word[%0d]", tag, c), fill_word, c - 4);
            checkOutput($sformatf("%s.done[%0d]", tag, c), own_done, (c == 12) ? 1 : 0);
            checkOutput($sformatf("%s.done_other[%0d]", tag, c), oth_done, 0);
            exp_stall = (c < 12) ? 1'b1 : (is_d ? icache_miss : dcache_miss);
            checkOutput($sformatf("%s.istall[%0d]", tag, c), istall, exp_stall);
            checkOutput($sformatf("%s.dstall[%0d]", tag, c), dstall, exp_stall);
            if (c == raise_other_at) begin
                if (is_d) begin
                    icache_miss = 1'b1;
                    icache_miss_addr = other_addr;
                end else begin
                    dcache_miss = 1'b1;
                    dcache_miss_addr = other_addr;
                end
            end
            if (c == drop_at) begin
                if (is_d) begin
                    dcache_miss = 1'b0;
                    dcache_miss_addr = 16'hFFFF;
                end else begin
                    icache_miss = 1'b0;
                    icache_miss_addr = 16'hFFFF;
                end
            end
            if (extra_valid && c == 11)
                stray_valid = 1'b1;
        end
        if (is_d)
            dcache_miss = 1'b0;
        else
            icache_miss = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stray_valid = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);

        // Reset state, including a miss raised while reset is held.
        @(negedge clk);
        checkOutput("rst.mem_addr", mem_addr, 0);
        checkOutput("rst.fill_word", fill_word, 0);
        checkQuiet("rst", 1'b0);
        applyStimulus(1'b1, 16'h1111, 1'b0, 16'h0000);
        @(negedge clk);
        checkQuiet("rst_miss", 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        checkQuiet("idle", 1'b0);

        // Single I miss at 0x1236.
        applyStimulus(1'b1, 16'h1236, 1'b0, 16'h0000);
        #1 checkOutput("req_i.istall", istall, 1);
        watchFill("fill_i", 1'b0, 16'h1230, -1, 16'h0, -1, 1'b0);
        @(negedge clk);
        checkQuiet("after_i", 1'b0);

        // Simultaneous requests: D first, one idle cycle, then I.
        applyStimulus(1'b1, 16'h2222, 1'b1, 16'h8000);
        watchFill("sim_d", 1'b1, 16'h8000, -1, 16'h0, -1, 1'b0);
        @(negedge clk);
        checkQuiet("sim_gap", 1'b1);
        watchFill("sim_i", 1'b0, 16'h2220, -1, 16'h0, -1, 1'b0);
        @(negedge clk);
        checkQuiet("after_sim", 1'b0);

        // D miss raised during an I fill.
        applyStimulus(1'b1, 16'h0A0C, 1'b0, 16'h0000);
        watchFill("mid_i", 1'b0, 16'h0A00, 5, 16'h4567, -1, 1'b0);
        @(negedge clk);
        checkQuiet("mid_gap", 1'b1);
        watchFill("mid_d", 1'b1, 16'h4560, -1, 16'h0, -1, 1'b0);
        @(negedge clk);
        checkQuiet("after_mid", 1'b0);

        // Stray valid in IDLE, then a 9th valid in DONE and the following IDLE.
        stray_valid = 1'b1;
        @(negedge clk);
        checkQuiet("stray_idle", 1'b0);
        stray_valid = 1'b0;
        applyStimulus(1'b1, 16'h0010, 1'b0, 16'h0000);
        watchFill("extra", 1'b0, 16'h0010, -1, 16'h0, -1, 1'b1);
        @(negedge clk);
        checkQuiet("extra_idle", 1'b0);
        stray_valid = 1'b0;
        @(negedge clk);
        checkQuiet("extra_idle2", 1'b0);

        // Reset pulsed at issue_cnt=3 abandons the fill.
        applyStimulus(1'b1, 16'h3000, 1'b0, 16'h0000);
        for (int c = 0; c <= 3; c++) @(negedge clk);
        checkOutput("rstmid.mem_addr_pre", mem_addr, 16'h3006);
        #2 rst = 1'b1;
        icache_miss = 1'b0;
        #1;
        checkOutput("rstmid.mem_addr", mem_addr, 0);
        checkOutput("rstmid.fill_word", fill_word, 0);
        checkQuiet("rstmid", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkQuiet($sformatf("late[%0d]", c), 1'b0);
        end
        applyStimulus(1'b1, 16'h3456, 1'b0, 16'h0000);
        watchFill("post_rst", 1'b0, 16'h3450, -1, 16'h0, -1, 1'b0);
        @(negedge clk);
        checkQuiet("after_post", 1'b0);

        // I miss dropped (and its address changed) once word 2 is written.
        applyStimulus(1'b1, 16'h5A5A, 1'b0, 16'h0000);
        watchFill("flush", 1'b0, 16'h5A50, -1, 16'h0, 6, 1'b0);
        @(negedge clk);
        checkQuiet("after_flush", 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
